// File: rtl/enc148_pkg.sv
// Shared types and helpers for the 74x148-style registered priority encoder.
package enc148_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int unsigned ENC_MAX_IN = 16;

  // Index of the highest set bit; 0 when nothing is set.
  function automatic logic [3:0] hi_index(input logic [ENC_MAX_IN-1:0] v);
    logic [3:0] r;
    r = '0;
    for (int unsigned i = 0; i < ENC_MAX_IN; i++) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/priority_encoder_148_prio_find.sv
// Combinational highest-index finder with an any-set flag.
module prio_find
  import enc148_pkg::*;
#(
  parameter  int N_IN = 8,
  localparam int CW   = $clog2(N_IN)
) (
  input  logic [N_IN-1:0] i_vec,
  output logic [CW-1:0]   o_idx,
  output logic            o_any
);

  logic [ENC_MAX_IN-1:0] w_ext;

  // Zero-extend to the helper's fixed width and pick the top bit.
  always_comb begin
    w_ext             = '0;
    w_ext[N_IN-1:0]   = i_vec;
    o_idx             = CW'(hi_index(w_ext));
    o_any             = |i_vec;
  end

endmodule

// File: rtl/priority_encoder_148.sv
// Registered, handshaked N_IN-to-CW priority encoder (74x148 style).
// Optional macro ENC_STICKY_EN: new requests join the running batch on each
// acceptance instead of waiting for the batch to empty.
module priority_encoder_148
  import enc148_pkg::*;
#(
  parameter  int N_IN = 8,
  localparam int CW   = $clog2(N_IN)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EN,
  input  logic [N_IN-1:0] I_L,
  output logic [CW-1:0]   A,
  output logic            VALID,
  input  logic            READY,
  output logic            GS,
  output logic            EO
);

  state_t            r_state;
  state_t            w_next;
  logic [N_IN-1:0]   r_pend;
  logic [N_IN-1:0]   w_pend_nxt;
  logic [CW-1:0]     r_a;
  logic [CW-1:0]     w_a_nxt;
  logic              r_gs;
  logic              r_eo;
  logic [N_IN-1:0]   w_req;
  logic [N_IN-1:0]   w_onehot;
  logic [N_IN-1:0]   w_rest;
  logic [CW-1:0]     w_idx;
  logic              w_any;

  assign w_req    = ~I_L;
  assign w_onehot = {{(N_IN-1){1'b0}}, 1'b1} << r_a;

  prio_find #(.N_IN(N_IN)) u_find (
    .i_vec (r_pend),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Batch remaining after the presented grant is accepted.
  always_comb begin
    w_rest = r_pend & ~w_onehot;
`ifdef ENC_STICKY_EN
    w_rest = w_rest | (w_req & ~w_onehot);
`else
    w_rest = w_rest;
`endif
  end

  // Next-state, next-batch and next-grant selection.
  always_comb begin
    w_next     = r_state;
    w_pend_nxt = r_pend;
    w_a_nxt    = r_a;
    case (r_state)
      IDLE: begin
        if (EN && (|w_req)) begin
          w_pend_nxt = w_req;
          w_next     = SEL;
        end
      end
      SEL: begin
        if (!EN || !w_any) begin
          w_pend_nxt = '0;
          w_next     = IDLE;
        end else begin
          w_a_nxt = w_idx;
          w_next  = OUT;
        end
      end
      OUT: begin
        if (READY) begin
          if ((|w_rest) && EN) begin
            w_pend_nxt = w_rest;
            w_next     = SEL;
          end else begin
            w_pend_nxt = '0;
            w_next     = IDLE;
          end
        end
      end
      default: begin
        w_pend_nxt = '0;
        w_next     = IDLE;
      end
    endcase
  end

  // State, batch, grant and the registered status flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_a     <= '0;
      r_gs    <= 1'b0;
      r_eo    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pend  <= w_pend_nxt;
      r_a     <= w_a_nxt;
      r_gs    <= (w_next != IDLE);
      r_eo    <= EN & ~(|w_req);
    end
  end

  assign A     = r_a;
  assign VALID = (r_state == OUT);
  assign GS    = r_gs;
  assign EO    = r_eo;

endmodule

// File: tb/tb_priority_encoder_148.sv
// Self-checking bench for priority_encoder_148 (N_IN = 8).
module tb_priority_encoder_148;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b0;
  logic       READY = 1'b0;
  logic [7:0] I_L = 8'hFF;
  logic [2:0] A;
  logic       VALID, GS, EO;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 selecting, 2 presenting.
  int         m_ph = 0;
  logic [7:0] m_pend = '0;
  logic [2:0] m_a = '0;
  logic       m_gs = 1'b0;
  logic       m_eo = 1'b0;

  always #5 CLK = ~CLK;

  priority_encoder_148 #(.N_IN(8)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .EN    (EN),
    .I_L   (I_L),
    .A     (A),
    .VALID (VALID),
    .READY (READY),
    .GS    (GS),
    .EO    (EO)
  );

  function automatic int top_bit(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_edge();
    logic [7:0] req, oh, rest;
    req = ~I_L;
    if (RST) begin
      m_ph = 0; m_pend = '0; m_a = '0; m_gs = 1'b0; m_eo = 1'b0;
    end else begin
      m_eo = EN && (req == 8'h00);
      if (m_ph == 0) begin
        if (EN && req != 8'h00) begin m_pend = req; m_ph = 1; end
      end else if (m_ph == 1) begin
        if (!EN) begin m_pend = '0; m_ph = 0; end
        else begin m_a = 3'(top_bit(m_pend)); m_ph = 2; end
      end else if (READY) begin
        oh   = 8'h01 << m_a;
        rest = m_pend & ~oh;
`ifdef ENC_STICKY_EN
        rest = rest | (req & ~oh);
`endif
        if (rest != 8'h00 && EN) begin m_pend = rest; m_ph = 1; end
        else begin m_pend = '0; m_ph = 0; end
      end
      m_gs = (m_ph != 0);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic hold_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (VALID === 1'b1) begin ok = 1'b1; return; end
      tick();
    end
    if (VALID === 1'b1) ok = 1'b1;
  endtask

  task automatic test_reset();
    I_L = 8'h00; EN = 1'b1; READY = 1'b0;
    hold_reset();
    checks++; if (A !== 3'd0)     begin errors++; $display("FAIL reset_A got %0d want 0", A); end
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL reset_VALID got %b want 0", VALID); end
    checks++; if (GS !== 1'b0)    begin errors++; $display("FAIL reset_GS got %b want 0", GS); end
    checks++; if (EO !== 1'b0)    begin errors++; $display("FAIL reset_EO got %b want 0", EO); end
    tick();
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL rel_VALID1 got %b want 0", VALID); end
    checks++; if (GS !== 1'b1)    begin errors++; $display("FAIL rel_GS got %b want 1", GS); end
    tick();
    checks++; if (VALID !== 1'b1) begin errors++; $display("FAIL rel_VALID2 got %b want 1", VALID); end
    checks++; if (A !== 3'd7)     begin errors++; $display("FAIL rel_A got %0d want 7", A); end
  endtask

  task automatic test_single();
    I_L = 8'b1111_1011; EN = 1'b1; READY = 1'b1;
    hold_reset();
    tick();
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL single_VALID0 got %b want 0", VALID); end
    checks++; if (GS !== 1'b1)    begin errors++; $display("FAIL single_GS got %b want 1", GS); end
    checks++; if (EO !== 1'b0)    begin errors++; $display("FAIL single_EO got %b want 0", EO); end
    tick();
    checks++; if (VALID !== 1'b1) begin errors++; $display("FAIL single_VALID1 got %b want 1", VALID); end
    checks++; if (A !== 3'd2)     begin errors++; $display("FAIL single_A got %0d want 2", A); end
  endtask

  task automatic test_batch();
    int exp_q[6] = '{7, 5, 0, 7, 5, 0};
    bit ok;
    I_L = 8'b0101_1110; EN = 1'b1; READY = 1'b1;
    hold_reset();
    for (int k = 0; k < 6; k++) begin
      wait_valid(10, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL batch_timeout grant %0d got none want %0d", k, exp_q[k]); end
      else if (A !== 3'(exp_q[k])) begin errors++; $display("FAIL batch_A grant %0d got %0d want %0d", k, A, exp_q[k]); end
      tick();
      if (k % 3 != 2) begin
        checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL batch_gap_low grant %0d got %b want 0", k, VALID); end
        tick();
        checks++; if (VALID !== 1'b1) begin errors++; $display("FAIL batch_gap_high grant %0d got %b want 1", k, VALID); end
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    I_L = 8'b0101_1110; EN = 1'b1; READY = 1'b0;
    hold_reset();
    wait_valid(10, ok);
    checks++; if (!ok || A !== 3'd7) begin errors++; $display("FAIL stall_first got %0d/%b want 7/1", A, ok); end
    READY = 1'b1;
    tick();
    READY = 1'b0;
    wait_valid(10, ok);
    checks++; if (!ok || A !== 3'd5) begin errors++; $display("FAIL stall_second got %0d/%b want 5/1", A, ok); end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (VALID !== 1'b1 || A !== 3'd5) begin
        errors++; $display("FAIL stall_hold cycle %0d got A=%0d V=%b want A=5 V=1", c, A, VALID);
      end
    end
    READY = 1'b1;
    tick();
    wait_valid(10, ok);
    checks++; if (!ok || A !== 3'd0) begin errors++; $display("FAIL stall_next got %0d/%b want 0/1", A, ok); end
  endtask

  task automatic test_eo();
    bit ok;
    I_L = 8'hFF; EN = 1'b0; READY = 1'b0;
    hold_reset();
    tick();
    checks++; if (EO !== 1'b0) begin errors++; $display("FAIL eo_disabled got %b want 0", EO); end
    EN = 1'b1;
    tick();
    checks++; if (EO !== 1'b1) begin errors++; $display("FAIL eo_enabled got %b want 1", EO); end
    I_L = 8'h7F;
    tick();
    checks++; if (EO !== 1'b0) begin errors++; $display("FAIL eo_request got %b want 0", EO); end
    wait_valid(10, ok);
    checks++; if (!ok || A !== 3'd7) begin errors++; $display("FAIL eo_grant got %0d/%b want 7/1", A, ok); end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++; if (VALID !== 1'b0 || GS !== 1'b0) begin errors++; $display("FAIL rst_in_out got V=%b GS=%b want 0 0", VALID, GS); end
  endtask

  task automatic test_sticky();
    bit ok;
    int e0, e1;
`ifdef ENC_STICKY_EN
    e0 = 6; e1 = 1;
`else
    e0 = 1; e1 = 6;
`endif
    I_L = ~8'h0A; EN = 1'b1; READY = 1'b0;
    hold_reset();
    wait_valid(10, ok);
    checks++; if (!ok || A !== 3'd3) begin errors++; $display("FAIL join_first got %0d/%b want 3/1", A, ok); end
    I_L = ~8'h4A; READY = 1'b1;
    tick();
    wait_valid(10, ok);
    checks++; if (!ok || A !== 3'(e0)) begin errors++; $display("FAIL join_second got %0d/%b want %0d/1", A, ok, e0); end
    tick();
    wait_valid(10, ok);
    checks++; if (!ok || A !== 3'(e1)) begin errors++; $display("FAIL join_third got %0d/%b want %0d/1", A, ok, e1); end
  endtask

  task automatic test_random();
    I_L = 8'hFF; EN = 1'b1; READY = 1'b0;
    hold_reset();
    for (int c = 0; c < 600; c++) begin
      RST   = ($urandom_range(0, 79) == 0);
      EN    = ($urandom_range(0, 9) != 0);
      READY = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) I_L = 8'($urandom);
      tick();
      checks++; if (A !== m_a) begin errors++; $display("FAIL rand_A cycle %0d got %0d want %0d", c, A, m_a); end
      checks++; if (VALID !== (m_ph == 2)) begin errors++; $display("FAIL rand_VALID cycle %0d got %b want %b", c, VALID, (m_ph == 2)); end
      checks++; if (GS !== m_gs) begin errors++; $display("FAIL rand_GS cycle %0d got %b want %b", c, GS, m_gs); end
      checks++; if (EO !== m_eo) begin errors++; $display("FAIL rand_EO cycle %0d got %b want %b", c, EO, m_eo); end
    end
    RST = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_batch();
    test_stall();
    test_eo();
    test_sticky();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
